seq_alu_muldiv: RTL
===================

// Module: seq_alu_muldiv
// PURPOSE
//  Parametrised multi-cycle ALU. It is the successor to the single-cycle combinational ALU.
//  It keeps that ALU's opcodes and result encodings unchanged, and adds SRA/SLT/SLTU,
//  iterative MUL/MULHU (shift-add) and DIVU/REMU (restoring), carry/overflow flags and
//  valid/ready handshakes on both sides. It sits between decode and writeback. Stall
//  logic uses InReady/OutValid.
// PARAMETERS
//  WIDTH      32  operand/result width; power of two, >=8
//  MULDIV_EN  1   1: iterative mul/div present; 0: mul/div codes behave as unsupported
// PORTS
//  CLK           in   1      clock, rising edge
//  RST           in   1      asynchronous reset, active-low
//  InValid       in   1      operation request
//  InReady       out  1      block can accept a request
//  SrcA          in   WIDTH  operand A
//  SrcB          in   WIDTH  operand B
//  ALUControl    in   4      opcode, sampled at accept
//  OutValid      out  1      result/flags valid
//  OutReady      in   1      consumer takes result
//  ALUResult     out  WIDTH  registered result
//  ZeroFlag      out  1      ALUResult==0
//  SignFlag      out  1      ALUResult[WIDTH-1]
//  CarryFlag     out  1      ADD carry-out; SUB 1 when no borrow (A>=B unsigned); else 0
//  OverflowFlag  out  1      signed overflow for ADD/SUB; else 0
// BEHAVIOUR
//  Opcodes:
//   0000 ADD   0001 SLL   0010 SUB   0011 SLT   0100 XOR   0101 SRL   0110 OR   0111 AND
//   1000 SRA   1001 SLTU  1010 MUL (low half)    1011 MULHU (high half, unsigned)
//   1100 DIVU  1101 REMU  1110/1111 -> result 0, single-cycle
//  Shift amount = SrcB[$clog2(WIDTH)-1:0]; upper bits of SrcB are ignored.
//  Reset (RST=0, async): FSM->IDLE, OutValid=0, ALUResult=0, all flags 0, counter=0.
//   Reset during BUSY aborts the operation; no result is produced.
//  FSM:
//   IDLE: InReady=1. On InValid, latch operands and opcode.
//    - Single-cycle op -> DONE. OutValid=1 on the next edge (latency 1).
//    - MUL/MULHU/DIVU/REMU with MULDIV_EN=1 -> BUSY, counter=WIDTH.
//   BUSY: InReady=0. One iteration per cycle; counter decrements.
//    At counter==1, result is written and state -> DONE.
//    Accept-to-OutValid latency = WIDTH+1 cycles.
//   DONE: OutValid=1, InReady=0. ALUResult and flags held stable until OutReady=1.
//    OutReady=1 -> IDLE, OutValid=0 on the next edge. A new request can be accepted the
//    cycle after that; there is no same-cycle accept/deliver.
//  Divide by zero (B=0): DIVU -> all ones; REMU -> SrcA. Latency is unchanged.
//  MUL/DIVU/REMU are unsigned; MUL low half is sign-agnostic.
//  SLT signed and SLTU unsigned: result 1 or 0, zero-extended to WIDTH.
//  ADD/SUB wrap modulo 2^WIDTH.
//  Flags are computed from the final ALUResult and update only on entry to DONE.
//  Inputs are ignored outside IDLE. InValid held across DONE is not a second accept until IDLE.
//  OutReady asserted while OutValid=0 has no effect.
// TESTING
//  1. RST low mid-BUSY (MUL at cycle 5) -> OutValid=0, ALUResult=0 immediately;
//     after release, InReady=1 next cycle.
//  2. ADD 0x7FFFFFFF+1 -> 1 cycle later 0x80000000, Sign=1, Overflow=1, Carry=0, Zero=0.
//     SUB 5-5 -> 0, Zero=1, Carry=1.
//  3. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE after 33 cycles.
//     MULHU same operands -> 0x00000001. InReady=0 throughout BUSY.
//  4. DIVU 100/7 -> 14; REMU -> 2. DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
//  5. OutReady=0 for 10 cycles in DONE -> ALUResult/flags stable, InValid ignored.
//     OutReady=1 -> IDLE next edge.
//  6. SRA 0x80000000 by SrcB=0x21 -> shamt 1 -> 0xC0000000.
//     SLT -1,1 -> 1; SLTU -1,1 -> 0. WIDTH=16 and MULDIV_EN=0 runs: MUL -> 0 in 1 cycle.

Source files
------------

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv
//   Multi-cycle ALU sitting between decode and writeback. Single-cycle ops
//   (ADD/SLL/SUB/SLT/XOR/SRL/OR/AND/SRA/SLTU, and the reserved codes) deliver
//   one cycle after accept. MUL/MULHU (shift-add) and DIVU/REMU (restoring)
//   iterate WIDTH cycles and deliver WIDTH+1 cycles after accept.
//   The result and flags are held in DONE until the consumer takes them.
//
// Ports
//   CLK           clock, rising edge
//   RST           asynchronous reset, active low
//   InValid       request from decode
//   InReady       block is idle and can accept a request
//   SrcA, SrcB    operands (WIDTH)
//   ALUControl    4-bit opcode, sampled on accept
//   OutValid      ALUResult and flags are valid
//   OutReady      consumer takes the result
//   ALUResult     registered result (WIDTH)
//   ZeroFlag      ALUResult == 0
//   SignFlag      ALUResult MSB
//   CarryFlag     ADD carry-out / SUB no-borrow; 0 for other ops
//   OverflowFlag  signed overflow for ADD/SUB; 0 for other ops
module seq_alu_muldiv #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MULDIV_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             ZeroFlag,
  output logic             SignFlag,
  output logic             CarryFlag,
  output logic             OverflowFlag
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SLL   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_SLT   = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_OR    = 4'b0110,
    OP_AND   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state, state_n;

  // Iterative datapath registers, shared by multiplier and divider:
  //   MUL: hi:lo is the partial product, lo starts as SrcB, opd = SrcA.
  //   DIV: hi is the partial remainder, lo shifts the dividend out and the
  //        quotient in, opd = divisor.
  logic [WIDTH-1:0] hi, lo, opd;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt;

  logic             is_md;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ov;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH-1:0] div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  logic             is_mul_q;
  logic [WIDTH-1:0] md_final;

  logic             load_en;
  logic [WIDTH-1:0] load_val;
  logic             load_c, load_v;

  assign is_md    = MULDIV_EN && (ALUControl inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU});
  assign shamt    = SrcB[SHW-1:0];
  assign is_mul_q = (op_q == OP_MUL) || (op_q == OP_MULHU);

  // Single-cycle result path
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ov    = 1'b0;
    add_full = {1'b0, SrcA} + {1'b0, SrcB};
    sub_full = {1'b0, SrcA} + {1'b0, ~SrcB} + (WIDTH+1)'(1);
    case (ALUControl)
      OP_ADD: begin
        sc_res   = add_full[WIDTH-1:0];
        sc_carry = add_full[WIDTH];
        sc_ov    = (SrcA[MSB] == SrcB[MSB]) && (sc_res[MSB] != SrcA[MSB]);
      end
      OP_SUB: begin
        sc_res   = sub_full[WIDTH-1:0];
        sc_carry = sub_full[WIDTH];
        sc_ov    = (SrcA[MSB] != SrcB[MSB]) && (sc_res[MSB] != SrcA[MSB]);
      end
      OP_SLL:  sc_res = SrcA << shamt;
      OP_SRL:  sc_res = SrcA >> shamt;
      OP_SRA:  sc_res = $signed(SrcA) >>> shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_XOR:  sc_res = SrcA ^ SrcB;
      OP_OR:   sc_res = SrcA | SrcB;
      OP_AND:  sc_res = SrcA & SrcB;
      // Reserved codes, and mul/div codes when the iterative unit is absent
      default: sc_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo[WIDTH-1:1]};

    // {hi, lo[MSB]} is WIDTH+1 bits wide; when it is >= opd the difference
    // fits in WIDTH bits, so the subtraction can be done modulo 2^WIDTH.
    div_shift = {hi[WIDTH-2:0], lo[MSB]};
    div_ge    = {hi, lo[MSB]} >= {1'b0, opd};
    div_hi_n  = div_ge ? (div_shift - opd) : div_shift;
    div_lo_n  = {lo[WIDTH-2:0], div_ge};

    case (op_q)
      OP_MUL:   md_final = mul_lo_n;
      OP_MULHU: md_final = mul_hi_n;
      OP_DIVU:  md_final = div_lo_n;
      default:  md_final = div_hi_n;
    endcase
  end

  // FSM: next state, handshakes and result-load strobe
  always_comb begin
    state_n  = state;
    InReady  = 1'b0;
    OutValid = 1'b0;
    load_en  = 1'b0;
    load_val = sc_res;
    load_c   = sc_carry;
    load_v   = sc_ov;
    case (state)
      S_IDLE: begin
        InReady = 1'b1;
        if (InValid) begin
          if (is_md) begin
            state_n = S_BUSY;
          end else begin
            state_n = S_DONE;
            load_en = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (cnt == CW'(1)) begin
          state_n  = S_DONE;
          load_en  = 1'b1;
          load_val = md_final;
          load_c   = 1'b0;
          load_v   = 1'b0;
        end
      end
      S_DONE: begin
        OutValid = 1'b1;
        if (OutReady) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALUResult    <= '0;
      ZeroFlag     <= 1'b0;
      SignFlag     <= 1'b0;
      CarryFlag    <= 1'b0;
      OverflowFlag <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      opd          <= '0;
      op_q         <= '0;
      cnt          <= '0;
    end else begin
      if (load_en) begin
        ALUResult    <= load_val;
        ZeroFlag     <= (load_val == '0);
        SignFlag     <= load_val[MSB];
        CarryFlag    <= load_c;
        OverflowFlag <= load_v;
      end
      case (state)
        S_IDLE: begin
          if (InValid && is_md) begin
            op_q <= ALUControl;
            cnt  <= CW'(WIDTH);
            hi   <= '0;
            if (ALUControl inside {OP_MUL, OP_MULHU}) begin
              lo  <= SrcB;
              opd <= SrcA;
            end else begin
              lo  <= SrcA;
              opd <= SrcB;
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt - CW'(1);
          hi  <= is_mul_q ? mul_hi_n : div_hi_n;
          lo  <= is_mul_q ? mul_lo_n : div_lo_n;
        end
        default: ;
      endcase
    end
  end

endmodule
